// File: rtl/drop_motion_seq.sv
// drop_motion_seq: frame-synchronous drop/bounce motion sequencer feeding draw_rect.
// Tracks the mouse in IDLE, drops under integer gravity on a left-button press,
// bounces off FLOOR_Y and either settles or bounces forever.
// Optional feature macro: BOUNCE_DAMP_EN (halve the rebound speed at every floor hit).
module drop_motion_seq #(
  parameter int FLOOR_Y   = 536,
  parameter int ACCEL_DIV = 3,
  parameter int MAX_SPEED = 63,
  parameter int SPEED_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        left_button,
  input  logic [11:0] xpos,
  input  logic [11:0] ypos,
  input  logic        vsync,
  output logic [11:0] xpos_out,
  output logic [11:0] ypos_out,
  output logic [1:0]  state_out,
  output logic        frame_tick
);

  localparam int DIV_W = (ACCEL_DIV > 1) ? $clog2(ACCEL_DIV) : 1;
  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(ACCEL_DIV - 1);
  localparam logic [SPEED_W-1:0] MAX_S    = SPEED_W'(MAX_SPEED);
  localparam logic signed [12:0] FLOOR_S  = 13'(FLOOR_Y);
  localparam logic [11:0]        FLOOR_U  = 12'(FLOOR_Y);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_FALL = 2'b01,
    S_RISE = 2'b10
  } state_t;

  state_t              r_state, w_state_n;
  logic [11:0]         r_x, r_y, w_x_n, w_y_n;
  logic [SPEED_W-1:0]  r_speed, w_speed_n, w_rebound;
  logic [DIV_W-1:0]    r_div, w_div_n;
  logic                r_vsync_d, r_btn_d, r_tick;
  logic                w_press;
  logic signed [12:0]  w_spd13, w_yfall, w_yrise, w_ymouse;

  // Clamp a signed 13-bit position into the drawable range [0, FLOOR_Y].
  function automatic logic [11:0] clamp_y(input logic signed [12:0] v);
    if (v < 13'sd0)        clamp_y = '0;
    else if (v > FLOOR_S)  clamp_y = FLOOR_U;
    else                   clamp_y = v[11:0];
  endfunction

  // Gravity increment saturating at MAX_SPEED.
  function automatic logic [SPEED_W-1:0] sat_inc(input logic [SPEED_W-1:0] s);
    if (s >= MAX_S) sat_inc = MAX_S;
    else            sat_inc = s + SPEED_W'(1);
  endfunction

  assign w_press  = left_button & ~r_btn_d;
  assign w_spd13  = signed'(13'(r_speed));
  assign w_yfall  = signed'({1'b0, r_y}) + w_spd13;
  assign w_yrise  = signed'({1'b0, r_y}) - w_spd13;
  assign w_ymouse = signed'({1'b0, ypos});

`ifdef BOUNCE_DAMP_EN
  assign w_rebound = r_speed >> 1;
`else
  assign w_rebound = r_speed;
`endif

  // Edge detectors for vsync and the button; frame_tick is the registered vsync rise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vsync_d <= 1'b0;
      r_btn_d   <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_vsync_d <= vsync;
      r_btn_d   <= left_button;
      r_tick    <= vsync & ~r_vsync_d;
    end
  end

  // State and motion registers; everything holds unless the next-state logic says otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_y     <= '0;
      r_speed <= '0;
      r_div   <= '0;
    end else begin
      r_state <= w_state_n;
      r_x     <= w_x_n;
      r_y     <= w_y_n;
      r_speed <= w_speed_n;
      r_div   <= w_div_n;
    end
  end

  // Next-state and motion update; a press outranks a frame tick in the same cycle.
  always_comb begin
    w_state_n = r_state;
    w_x_n     = r_x;
    w_y_n     = r_y;
    w_speed_n = r_speed;
    w_div_n   = r_div;
    case (r_state)
      S_IDLE: begin
        if (w_press || r_tick) begin
          w_x_n     = xpos;
          w_y_n     = clamp_y(w_ymouse);
          w_speed_n = '0;
          w_div_n   = '0;
          if (w_press) w_state_n = S_FALL;
        end
      end
      S_FALL: begin
        if (w_press) begin
          w_state_n = S_IDLE;
          w_speed_n = '0;
          w_div_n   = '0;
        end else if (r_tick) begin
          if (w_yfall >= FLOOR_S) begin
            w_y_n   = FLOOR_U;
            w_div_n = '0;
            if (w_rebound == '0) begin
              w_speed_n = '0;
              w_state_n = S_IDLE;
            end else begin
              w_speed_n = w_rebound;
              w_state_n = S_RISE;
            end
          end else begin
            w_y_n = w_yfall[11:0];
            if (r_div == DIV_LAST) begin
              w_div_n   = '0;
              w_speed_n = sat_inc(r_speed);
            end else begin
              w_div_n = r_div + DIV_W'(1);
            end
          end
        end
      end
      S_RISE: begin
        if (w_press) begin
          w_state_n = S_IDLE;
          w_speed_n = '0;
          w_div_n   = '0;
        end else if (r_tick) begin
          w_y_n = clamp_y(w_yrise);
          if (r_div == DIV_LAST) begin
            w_div_n = '0;
            if (r_speed <= SPEED_W'(1)) begin
              w_speed_n = '0;
              w_state_n = S_FALL;
            end else begin
              w_speed_n = r_speed - SPEED_W'(1);
            end
          end else begin
            w_div_n = r_div + DIV_W'(1);
          end
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  assign xpos_out   = r_x;
  assign ypos_out   = r_y;
  assign state_out  = r_state;
  assign frame_tick = r_tick;

endmodule

// File: tb/tb_drop_motion_seq.sv
// tb_drop_motion_seq: directed and randomized checks of drop_motion_seq against
// a frame-level physics model of the object (position, speed, gravity phase).
module tb_drop_motion_seq;

  localparam int FLOOR = 536;
  localparam int ADIV  = 3;
  localparam int VMAX  = 63;
`ifdef BOUNCE_DAMP_EN
  localparam int DAMP = 1;
`else
  localparam int DAMP = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        left_button = 1'b0;
  logic [11:0] xpos = '0;
  logic [11:0] ypos = '0;
  logic        vsync = 1'b0;
  logic [11:0] xpos_out, ypos_out;
  logic [1:0]  state_out;
  logic        frame_tick;

  drop_motion_seq dut (
    .clk(clk), .rst(rst), .left_button(left_button), .xpos(xpos), .ypos(ypos),
    .vsync(vsync), .xpos_out(xpos_out), .ypos_out(ypos_out),
    .state_out(state_out), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Physics model: mode 0 tracking, 1 falling, 2 rising.
  int m_x, m_y, m_v, m_ph, m_mode;
  logic obs_tick;

  task automatic m_reset();
    m_x = 0; m_y = 0; m_v = 0; m_ph = 0; m_mode = 0;
  endtask

  task automatic m_press(input int x, input int y);
    if (m_mode == 0) begin
      m_x = x; m_y = (y > FLOOR) ? FLOOR : y; m_v = 0; m_ph = 0; m_mode = 1;
    end else begin
      m_mode = 0; m_v = 0; m_ph = 0;
    end
  endtask

  task automatic m_frame(input int x, input int y);
    int ny, r;
    if (m_mode == 0) begin
      m_x = x; m_y = (y > FLOOR) ? FLOOR : y; m_v = 0; m_ph = 0;
    end else if (m_mode == 1) begin
      ny = m_y + m_v;
      if (ny >= FLOOR) begin
        m_y = FLOOR;
        r = DAMP ? m_v / 2 : m_v;
        m_ph = 0;
        if (r == 0) begin m_mode = 0; m_v = 0; end
        else begin m_mode = 2; m_v = r; end
      end else begin
        m_y = ny;
        m_ph++;
        if (m_ph == ADIV) begin
          m_ph = 0;
          m_v = (m_v + 1 > VMAX) ? VMAX : m_v + 1;
        end
      end
    end else begin
      m_y = (m_y - m_v < 0) ? 0 : m_y - m_v;
      m_ph++;
      if (m_ph == ADIV) begin
        m_ph = 0;
        m_v--;
        if (m_v == 0) m_mode = 1;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One frame: vsync high for one cycle; the update lands on the following edge.
  task automatic do_frame(input int x, input int y);
    xpos = 12'(x); ypos = 12'(y);
    vsync = 1'b1;
    step();
    obs_tick = frame_tick;
    vsync = 1'b0;
    step();
    m_frame(x, y);
  endtask

  task automatic do_press(input int x, input int y);
    xpos = 12'(x); ypos = 12'(y);
    left_button = 1'b1;
    step();
    m_press(x, y);
    left_button = 1'b0;
    step();
  endtask

  // Press arrives in the same cycle the frame tick is presented.
  task automatic do_press_on_tick(input int x, input int y);
    xpos = 12'(x); ypos = 12'(y);
    vsync = 1'b1;
    step();
    obs_tick = frame_tick;
    vsync = 1'b0;
    left_button = 1'b1;
    step();
    m_press(x, y);
    left_button = 1'b0;
    step();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    left_button = 1'($urandom_range(0, 1));
    vsync = 1'($urandom_range(0, 1));
    xpos = 12'($urandom); ypos = 12'($urandom);
    step();
    rst = 1'b0; left_button = 1'b0; vsync = 1'b0;
    step();
    m_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      left_button = 1'($urandom_range(0, 1));
      vsync = 1'($urandom_range(0, 1));
      xpos = 12'($urandom); ypos = 12'($urandom);
      step();
    end
    n_checks++;
    if ({xpos_out, ypos_out, state_out, frame_tick} !== 27'd0) begin
      n_errors++;
      $display("FAIL reset: x=%0d y=%0d st=%0d tick=%0d, required all zero",
               xpos_out, ypos_out, state_out, frame_tick);
    end
    rst = 1'b0; left_button = 1'b0; vsync = 1'b0;
    step();
    m_reset();
    n_checks++;
    if ({xpos_out, ypos_out, state_out, frame_tick} !== 27'd0) begin
      n_errors++;
      $display("FAIL reset_release: x=%0d y=%0d st=%0d tick=%0d, required all zero",
               xpos_out, ypos_out, state_out, frame_tick);
    end
  endtask

  task automatic test_idle_track();
    do_frame(100, 600);
    n_checks++;
    if (obs_tick !== 1'b1) begin
      n_errors++;
      $display("FAIL tick_pulse: frame_tick=%0d, required 1", obs_tick);
    end
    n_checks++;
    if (frame_tick !== 1'b0) begin
      n_errors++;
      $display("FAIL tick_width: frame_tick=%0d, required 0", frame_tick);
    end
    n_checks++;
    if ({xpos_out, ypos_out, state_out} !== {12'd100, 12'd536, 2'd0}) begin
      n_errors++;
      $display("FAIL idle_track: x=%0d y=%0d st=%0d, required x=100 y=536 st=0",
               xpos_out, ypos_out, state_out);
    end
  endtask

  task automatic test_drop();
    int exp_y[6];
    exp_y = '{500, 500, 500, 501, 502, 503};
    do_press(300, 500);
    n_checks++;
    if ({xpos_out, ypos_out, state_out} !== {12'd300, 12'd500, 2'd1}) begin
      n_errors++;
      $display("FAIL drop_latch: x=%0d y=%0d st=%0d, required x=300 y=500 st=1",
               xpos_out, ypos_out, state_out);
    end
    for (int i = 0; i < 6; i++) begin
      do_frame($urandom_range(0, 4095), $urandom_range(0, 4095));
      n_checks++;
      if ({xpos_out, ypos_out, state_out} !== {12'd300, 12'(exp_y[i]), 2'd1}) begin
        n_errors++;
        $display("FAIL drop_tick%0d: x=%0d y=%0d st=%0d, required x=300 y=%0d st=1",
                 i + 1, xpos_out, ypos_out, state_out, exp_y[i]);
      end
    end
    // speed is 2 after the sixth tick, so the next tick moves by 2
    do_frame(1, 1);
    n_checks++;
    if (ypos_out !== 12'd505) begin
      n_errors++;
      $display("FAIL drop_speed2: y=%0d, required 505", ypos_out);
    end
  endtask

  task automatic test_floor_bounce();
    int ymark;
    do_reset();
    do_press(40, 448);
    for (int i = 0; i < 24; i++) do_frame($urandom_range(0, 4095), $urandom_range(0, 700));
    n_checks++;
    if ({ypos_out, state_out} !== {12'd532, 2'd1}) begin
      n_errors++;
      $display("FAIL pre_floor: y=%0d st=%0d, required y=532 st=1", ypos_out, state_out);
    end
    do_frame(5, 5);
    n_checks++;
    if ({xpos_out, ypos_out, state_out} !== {12'd40, 12'd536, 2'd2}) begin
      n_errors++;
      $display("FAIL floor_hit: x=%0d y=%0d st=%0d, required x=40 y=536 st=2",
               xpos_out, ypos_out, state_out);
    end
    do_frame(5, 5);
    n_checks++;
    if (ypos_out !== 12'(DAMP ? 532 : 528)) begin
      n_errors++;
      $display("FAIL rebound_speed: y=%0d, required %0d", ypos_out, DAMP ? 532 : 528);
    end
    ymark = int'(ypos_out);
    do_press_on_tick(9, 9);
    n_checks++;
    if ({ypos_out, state_out} !== {12'(ymark), 2'd0}) begin
      n_errors++;
      $display("FAIL abort_on_tick: y=%0d st=%0d, required y=%0d st=0", ypos_out, state_out, ymark);
    end
    do_frame(77, 123);
    n_checks++;
    if ({xpos_out, ypos_out, state_out} !== {12'd77, 12'd123, 2'd0}) begin
      n_errors++;
      $display("FAIL abort_resync: x=%0d y=%0d st=%0d, required x=77 y=123 st=0",
               xpos_out, ypos_out, state_out);
    end
  endtask

  task automatic test_long_drop();
    int max_y, frames, mism, saw_idle;
    do_reset();
    do_press(200, 0);
    max_y = 0; frames = 0; mism = 0; saw_idle = 0;
    while (frames < 2000 && saw_idle == 0) begin
      do_frame($urandom_range(0, 4095), $urandom_range(0, 4095));
      frames++;
      if (int'(ypos_out) > max_y) max_y = int'(ypos_out);
      if ({xpos_out, ypos_out, state_out} !== {12'(m_x), 12'(m_y), 2'(m_mode)}) mism++;
      if (state_out == 2'd0) saw_idle = 1;
      if (DAMP == 0 && frames >= 400) frames = 2000;
    end
    n_checks++;
    if (max_y > FLOOR) begin
      n_errors++;
      $display("FAIL floor_bound: max y=%0d, required <= %0d", max_y, FLOOR);
    end
    n_checks++;
    if (mism != 0) begin
      n_errors++;
      $display("FAIL long_drop_model: %0d frame mismatches, required 0", mism);
    end
    n_checks++;
    if (saw_idle != DAMP) begin
      n_errors++;
      $display("FAIL settle: reached idle=%0d, required %0d (y=%0d st=%0d)",
               saw_idle, DAMP, ypos_out, state_out);
    end
    if (DAMP != 0) begin
      n_checks++;
      if (ypos_out !== 12'd536) begin
        n_errors++;
        $display("FAIL settle_pos: y=%0d, required 536", ypos_out);
      end
    end
  endtask

  task automatic test_random();
    int op, x, y;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 99);
      x = $urandom_range(0, 4095);
      y = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 4095) : $urandom_range(0, 700);
      if (op < 70) begin
        do_frame(x, y);
        n_checks++;
        if (obs_tick !== 1'b1) begin
          n_errors++;
          $display("FAIL rand_tick[%0d]: frame_tick=%0d, required 1", i, obs_tick);
        end
      end else if (op < 82) begin
        do_press(x, y);
      end else if (op < 88) begin
        do_press_on_tick(x, y);
      end else if (op < 97) begin
        xpos = 12'(x); ypos = 12'(y);
        for (int k = 0; k < 3; k++) step();
      end else begin
        do_reset();
      end
      n_checks++;
      if ({xpos_out, ypos_out, state_out} !== {12'(m_x), 12'(m_y), 2'(m_mode)}) begin
        n_errors++;
        $display("FAIL rand[%0d] op=%0d: x=%0d y=%0d st=%0d, required x=%0d y=%0d st=%0d",
                 i, op, xpos_out, ypos_out, state_out, m_x, m_y, m_mode);
      end
    end
  endtask

  initial begin
    m_reset();
    obs_tick = 1'b0;
    test_reset();
    test_idle_track();
    test_drop();
    test_floor_bounce();
    test_long_drop();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
